// File: rtl/alu_ctrl_fsm_if.sv
// Bus between the ALU control sequencer and its surroundings: fetch handshake,
// register-file read/write ports, ALU issue port, flags and status.
interface alu_ctrl_fsm_if #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3
);
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic              instr_ready;

    logic [RA_W-1:0]   rf_ra_a;
    logic [RA_W-1:0]   rf_ra_b;
    logic [DATA_W-1:0] rf_rd_a;
    logic [DATA_W-1:0] rf_rd_b;

    logic              alu_enable;
    logic [4:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;

    logic              rf_we;
    logic [RA_W-1:0]   rf_wa;
    logic [DATA_W-1:0] rf_wd;

    logic              flag_z;
    logic              flag_n;
    logic              branch_taken;
    logic [DATA_W-1:0] branch_off;
    logic              busy;
    logic              halted;

    // The sequencer drives the ALU and register file.
    modport master (
        input  instr_valid, instr, rf_rd_a, rf_rd_b, alu_result,
        output instr_ready, rf_ra_a, rf_ra_b, alu_enable, alu_op, alu_a, alu_b,
               rf_we, rf_wa, rf_wd, flag_z, flag_n, branch_taken, branch_off,
               busy, halted
    );

    modport slave (
        output instr_valid, instr, rf_rd_a, rf_rd_b, alu_result,
        input  instr_ready, rf_ra_a, rf_ra_b, alu_enable, alu_op, alu_a, alu_b,
               rf_we, rf_wa, rf_wd, flag_z, flag_n, branch_taken, branch_off,
               busy, halted
    );
endinterface

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle ALU control sequencer: IDLE -> DECODE -> EXEC -> WB, one
// instruction per four cycles, with a sticky HALT state.
module alu_ctrl_fsm #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    alu_ctrl_fsm_if.master  bus
);
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, HALT} state_t;

    localparam logic [4:0] OP_CMP  = 5'b01000;
    localparam logic [4:0] OP_BEQ  = 5'b01001;
    localparam logic [4:0] OP_BNE  = 5'b01010;
    localparam logic [4:0] OP_HALT = 5'b11111;

    state_t            state;
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] result_q;
    logic [4:0]        opcode;
    logic [4:0]        op_in;
    logic [RA_W-1:0]   rd_q;
    logic              branch_cond;

    assign opcode = instr_q[15:11];
    assign op_in  = bus.instr[15:11];
    assign rd_q   = instr_q[10:8];

    function automatic logic is_branch(input logic [4:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    // ALU ops 00000..00111 and CMP update flags; MOV and branches leave them alone.
    function automatic logic is_flag_op(input logic [4:0] op);
        return op <= OP_CMP;
    endfunction

    function automatic logic is_wb_op(input logic [4:0] op);
        return (op < OP_CMP) || ((op > OP_BNE) && (op != OP_HALT));
    endfunction

    assign branch_cond = (opcode == OP_BEQ) ? (result_q == '0) : (result_q != '0);

    assign bus.instr_ready = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.halted      = (state == HALT);

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: every register, including the datapath captures, is reset so an
        // aborted instruction leaves nothing behind.
        if (!reset_n) begin
            state            <= IDLE;
            instr_q          <= '0;
            result_q         <= '0;
            bus.rf_ra_a      <= '0;
            bus.rf_ra_b      <= '0;
            bus.alu_enable   <= 1'b0;
            bus.alu_op       <= '0;
            bus.alu_a        <= '0;
            bus.alu_b        <= '0;
            bus.rf_we        <= 1'b0;
            bus.rf_wa        <= '0;
            bus.rf_wd        <= '0;
            bus.flag_z       <= 1'b0;
            bus.flag_n       <= 1'b0;
            bus.branch_taken <= 1'b0;
            bus.branch_off   <= '0;
        end else begin
            // NOTE: non-blocking everywhere; the pulse defaults below are simply
            // overridden by a later assignment in the WB branch.
            bus.rf_we        <= 1'b0;
            bus.rf_wa        <= '0;
            bus.rf_wd        <= '0;
            bus.branch_taken <= 1'b0;
            bus.branch_off   <= '0;

            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        // Branches compare rd against rs1.
                        bus.rf_ra_a <= is_branch(op_in) ? bus.instr[10:8] : bus.instr[7:5];
                        bus.rf_ra_b <= is_branch(op_in) ? bus.instr[7:5]  : bus.instr[4:2];
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    bus.rf_ra_a <= '0;
                    bus.rf_ra_b <= '0;
                    if (opcode == OP_HALT) begin
                        state <= HALT;
                    end else begin
                        bus.alu_enable <= 1'b1;
                        bus.alu_op     <= opcode;
                        bus.alu_a      <= bus.rf_rd_a;
                        bus.alu_b      <= bus.rf_rd_b;
                        state          <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= bus.alu_result;
                    if (is_flag_op(opcode)) begin
                        bus.flag_z <= (bus.alu_result == '0);
                        bus.flag_n <= bus.alu_result[DATA_W-1];
                    end
                    bus.alu_enable <= 1'b0;
                    bus.alu_op     <= '0;
                    bus.alu_a      <= '0;
                    bus.alu_b      <= '0;
                    state          <= WB;
                end
                WB: begin
                    if (is_wb_op(opcode)) begin
                        bus.rf_we <= 1'b1;
                        bus.rf_wa <= rd_q;
                        bus.rf_wd <= result_q;
                    end else if (is_branch(opcode) && branch_cond) begin
                        bus.branch_taken <= 1'b1;
                        bus.branch_off   <= {{(DATA_W-5){instr_q[4]}}, instr_q[4:0]};
                    end
                    state <= IDLE;
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed self-checking bench for alu_ctrl_fsm with a small register file
// and a combinational reference ALU around the sequencer.
module tb_alu_ctrl_fsm;
    logic clk;
    logic reset_n;
    logic [15:0] regs [8];
    int n_tests = 0;
    int n_fail  = 0;

    alu_ctrl_fsm_if #(.DATA_W(16), .RA_W(3)) bus ();

    alu_ctrl_fsm #(.DATA_W(16), .RA_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rf_rd_a = regs[bus.rf_ra_a];
    assign bus.rf_rd_b = regs[bus.rf_ra_b];

    // Reference ALU; output is forced to zero when not enabled.
    always_comb begin
        bus.alu_result = 16'h0000;
        if (bus.alu_enable) begin
            case (bus.alu_op)
                5'b00000: bus.alu_result = bus.alu_a ^ bus.alu_b;
                5'b00001: bus.alu_result = bus.alu_a + bus.alu_b;
                5'b00010: bus.alu_result = bus.alu_a - bus.alu_b;
                5'b00011: bus.alu_result = bus.alu_a + 16'd1;
                5'b00100: bus.alu_result = bus.alu_a - 16'd1;
                5'b00101: bus.alu_result = bus.alu_a & bus.alu_b;
                5'b00110: bus.alu_result = bus.alu_a | bus.alu_b;
                5'b00111: bus.alu_result = ~bus.alu_a;
                5'b01000, 5'b01001, 5'b01010: bus.alu_result = bus.alu_a - bus.alu_b;
                default:  bus.alu_result = bus.alu_a;
            endcase
        end
    end

    // Observations from the last run_instr call.
    int          obs_we_cnt, obs_we_cyc, obs_br_cnt, obs_br_cyc, obs_both;
    logic [2:0]  obs_wa, obs_ra_a, obs_ra_b;
    logic [15:0] obs_wd, obs_boff, obs_a, obs_b;
    logic        obs_ena;
    logic [4:0]  obs_op;
    logic [6:1]  obs_rdy;

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 2'b00};
    endfunction

    // Handshake one instruction (edge E0) and observe the following six cycles.
    task automatic run_instr(input logic [15:0] word);
        @(negedge clk);
        bus.instr       = word;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        obs_we_cnt = 0; obs_we_cyc = 0; obs_br_cnt = 0; obs_br_cyc = 0; obs_both = 0;
        obs_wa = '0; obs_wd = '0; obs_boff = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            obs_rdy[k] = bus.instr_ready;
            if (k == 1) begin obs_ra_a = bus.rf_ra_a; obs_ra_b = bus.rf_ra_b; end
            if (k == 2) begin
                obs_ena = bus.alu_enable; obs_op = bus.alu_op;
                obs_a = bus.alu_a; obs_b = bus.alu_b;
            end
            if (bus.rf_we) begin
                obs_we_cnt++; obs_we_cyc = k; obs_wa = bus.rf_wa; obs_wd = bus.rf_wd;
            end
            if (bus.branch_taken) begin
                obs_br_cnt++; obs_br_cyc = k; obs_boff = bus.branch_off;
            end
            if (bus.rf_we && bus.branch_taken) obs_both++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = 16'h0000;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.instr_ready); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_tests++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
        n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b want 0", bus.rf_we); end
        n_tests++; if (bus.alu_enable !== 1'b0) begin n_fail++; $display("FAIL reset_alu_enable: got %b want 0", bus.alu_enable); end
        n_tests++; if ({bus.flag_z, bus.flag_n} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {bus.flag_z, bus.flag_n}); end
        n_tests++; if (bus.branch_taken !== 1'b0) begin n_fail++; $display("FAIL reset_branch: got %b want 0", bus.branch_taken); end
        n_tests++; if (bus.rf_wd !== 16'h0000) begin n_fail++; $display("FAIL reset_rf_wd: got %h want 0000", bus.rf_wd); end
        reset_n = 1'b1;
    endtask

    task automatic test_add;
        run_instr(enc(5'b00001, 3'd3, 3'd1, 3'd2));
        n_tests++; if (obs_ena !== 1'b1 || obs_op !== 5'b00001) begin n_fail++; $display("FAIL add_issue: got en=%b op=%b want en=1 op=00001", obs_ena, obs_op); end
        n_tests++; if (obs_a !== 16'd5 || obs_b !== 16'd7) begin n_fail++; $display("FAIL add_operands: got %h/%h want 0005/0007", obs_a, obs_b); end
        n_tests++; if (obs_we_cnt !== 1 || obs_we_cyc !== 4) begin n_fail++; $display("FAIL add_we_timing: got cnt=%0d cyc=%0d want cnt=1 cyc=4", obs_we_cnt, obs_we_cyc); end
        n_tests++; if (obs_wa !== 3'd3 || obs_wd !== 16'h000C) begin n_fail++; $display("FAIL add_wb: got wa=%0d wd=%h want wa=3 wd=000c", obs_wa, obs_wd); end
        n_tests++; if ({bus.flag_z, bus.flag_n} !== 2'b00) begin n_fail++; $display("FAIL add_flags: got %b want 00", {bus.flag_z, bus.flag_n}); end
        n_tests++; if (obs_rdy !== 6'b111000) begin n_fail++; $display("FAIL add_ready: got %b want 111000", obs_rdy); end
    endtask

    task automatic test_sub_inc;
        run_instr(enc(5'b00010, 3'd5, 3'd3, 3'd4));
        n_tests++; if (obs_we_cnt !== 1 || obs_wa !== 3'd5 || obs_wd !== 16'hFFFE) begin n_fail++; $display("FAIL sub_wb: got cnt=%0d wa=%0d wd=%h want 1/5/fffe", obs_we_cnt, obs_wa, obs_wd); end
        n_tests++; if ({bus.flag_z, bus.flag_n} !== 2'b01) begin n_fail++; $display("FAIL sub_flags: got zn=%b want 01", {bus.flag_z, bus.flag_n}); end
        run_instr(enc(5'b00011, 3'd7, 3'd6, 3'd0));
        n_tests++; if (obs_we_cnt !== 1 || obs_wa !== 3'd7 || obs_wd !== 16'h0000) begin n_fail++; $display("FAIL inc_wb: got cnt=%0d wa=%0d wd=%h want 1/7/0000", obs_we_cnt, obs_wa, obs_wd); end
        n_tests++; if ({bus.flag_z, bus.flag_n} !== 2'b10) begin n_fail++; $display("FAIL inc_flags: got zn=%b want 10", {bus.flag_z, bus.flag_n}); end
    endtask

    task automatic test_cmp;
        run_instr(enc(5'b00110, 3'd0, 3'd5, 3'd7));
        n_tests++; if (obs_wd !== 16'h8001 || {bus.flag_z, bus.flag_n} !== 2'b01) begin n_fail++; $display("FAIL or_result: got wd=%h zn=%b want 8001/01", obs_wd, {bus.flag_z, bus.flag_n}); end
        regs[1] = 16'h1234;
        regs[2] = 16'h1234;
        run_instr(enc(5'b01000, 3'd6, 3'd1, 3'd2));
        n_tests++; if (obs_we_cnt !== 0) begin n_fail++; $display("FAIL cmp_no_we: got %0d pulses want 0", obs_we_cnt); end
        n_tests++; if ({bus.flag_z, bus.flag_n} !== 2'b10) begin n_fail++; $display("FAIL cmp_flags: got zn=%b want 10", {bus.flag_z, bus.flag_n}); end
    endtask

    task automatic test_branch;
        run_instr(enc(5'b00010, 3'd5, 3'd3, 3'd4));
        run_instr({5'b01001, 3'd1, 3'd2, 5'b11110});
        n_tests++; if (obs_ra_a !== 3'd1 || obs_ra_b !== 3'd2) begin n_fail++; $display("FAIL beq_raddr: got %0d/%0d want 1/2", obs_ra_a, obs_ra_b); end
        n_tests++; if (obs_br_cnt !== 1 || obs_br_cyc !== 4) begin n_fail++; $display("FAIL beq_pulse: got cnt=%0d cyc=%0d want 1/4", obs_br_cnt, obs_br_cyc); end
        n_tests++; if (obs_boff !== 16'hFFFE) begin n_fail++; $display("FAIL beq_off: got %h want fffe", obs_boff); end
        n_tests++; if (obs_we_cnt !== 0 || obs_both !== 0) begin n_fail++; $display("FAIL beq_no_we: got we=%0d both=%0d want 0/0", obs_we_cnt, obs_both); end
        n_tests++; if ({bus.flag_z, bus.flag_n} !== 2'b01) begin n_fail++; $display("FAIL beq_flags: got zn=%b want 01", {bus.flag_z, bus.flag_n}); end
        run_instr({5'b01010, 3'd1, 3'd2, 5'b11110});
        n_tests++; if (obs_br_cnt !== 0 || obs_we_cnt !== 0) begin n_fail++; $display("FAIL bne_no_pulse: got br=%0d we=%0d want 0/0", obs_br_cnt, obs_we_cnt); end
        n_tests++; if ({bus.flag_z, bus.flag_n} !== 2'b01) begin n_fail++; $display("FAIL bne_flags: got zn=%b want 01", {bus.flag_z, bus.flag_n}); end
    endtask

    task automatic test_mov;
        run_instr(enc(5'b01100, 3'd4, 3'd1, 3'd3));
        n_tests++; if (obs_op !== 5'b01100) begin n_fail++; $display("FAIL mov_op: got %b want 01100", obs_op); end
        n_tests++; if (obs_we_cnt !== 1 || obs_wa !== 3'd4 || obs_wd !== 16'h1234) begin n_fail++; $display("FAIL mov_wb: got cnt=%0d wa=%0d wd=%h want 1/4/1234", obs_we_cnt, obs_wa, obs_wd); end
        n_tests++; if ({bus.flag_z, bus.flag_n} !== 2'b01) begin n_fail++; $display("FAIL mov_flags: got zn=%b want 01", {bus.flag_z, bus.flag_n}); end
    endtask

    task automatic test_back_to_back;
        logic [12:1] rdy_m, we_m;
        int bad_wd;
        regs[1] = 16'd5;
        regs[2] = 16'd7;
        bad_wd = 0;
        @(negedge clk);
        bus.instr       = enc(5'b00001, 3'd3, 3'd1, 3'd2);
        bus.instr_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            rdy_m[k] = bus.instr_ready;
            we_m[k]  = bus.rf_we;
            if (bus.rf_we && bus.rf_wd !== 16'h000C) bad_wd++;
        end
        bus.instr_valid = 1'b0;
        n_tests++; if (rdy_m !== 12'b100010001000) begin n_fail++; $display("FAIL b2b_ready: got %b want 100010001000", rdy_m); end
        n_tests++; if (we_m !== 12'b100010001000) begin n_fail++; $display("FAIL b2b_we: got %b want 100010001000", we_m); end
        n_tests++; if (bad_wd !== 0) begin n_fail++; $display("FAIL b2b_wd: got %0d wrong writes want 0", bad_wd); end
        repeat (2) @(negedge clk);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_halt;
        int bad, ena_seen;
        bad = 0;
        ena_seen = 0;
        @(negedge clk);
        bus.instr       = 16'hFFFF;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr = enc(5'b00001, 3'd3, 3'd1, 3'd2);
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (bus.alu_enable || bus.rf_we) ena_seen++;
            if (k >= 2 && (bus.halted !== 1'b1 || bus.instr_ready !== 1'b0 || bus.busy !== 1'b1)) bad++;
        end
        bus.instr_valid = 1'b0;
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL halt_hold: got %0d bad cycles want 0", bad); end
        n_tests++; if (ena_seen !== 0) begin n_fail++; $display("FAIL halt_quiet: got %0d active cycles want 0", ena_seen); end
    endtask

    task automatic test_reset_mid;
        int we_seen;
        we_seen = 0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_tests++; if (bus.halted !== 1'b0 || bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL halt_release: got halted=%b ready=%b want 0/1", bus.halted, bus.instr_ready); end
        run_instr(enc(5'b00010, 3'd5, 3'd3, 3'd4));
        n_tests++; if (bus.flag_n !== 1'b1) begin n_fail++; $display("FAIL pre_abort_flag_n: got %b want 1", bus.flag_n); end
        @(negedge clk);
        bus.instr       = enc(5'b00001, 3'd3, 3'd1, 3'd2);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (bus.alu_enable !== 1'b1) begin n_fail++; $display("FAIL abort_in_exec: got alu_enable=%b want 1", bus.alu_enable); end
        reset_n = 1'b0;
        #1;
        n_tests++; if (bus.instr_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got ready=%b busy=%b want 1/0", bus.instr_ready, bus.busy); end
        n_tests++; if (bus.alu_enable !== 1'b0 || bus.alu_a !== 16'h0000 || bus.alu_op !== 5'd0) begin n_fail++; $display("FAIL abort_alu: got en=%b a=%h op=%b want 0/0000/00000", bus.alu_enable, bus.alu_a, bus.alu_op); end
        n_tests++; if ({bus.flag_z, bus.flag_n} !== 2'b00) begin n_fail++; $display("FAIL abort_flags: got zn=%b want 00", {bus.flag_z, bus.flag_n}); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.rf_we || bus.branch_taken) we_seen++;
        end
        n_tests++; if (we_seen !== 0) begin n_fail++; $display("FAIL abort_no_we: got %0d pulses want 0", we_seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        regs[0] = 16'h0000; regs[1] = 16'h0005; regs[2] = 16'h0007; regs[3] = 16'h0003;
        regs[4] = 16'h0005; regs[5] = 16'h8000; regs[6] = 16'hFFFF; regs[7] = 16'h0001;
        test_reset();
        test_add();
        test_sub_inc();
        test_cmp();
        test_branch();
        test_mov();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
